fifo_width_down_conv: RTL and testbench

Parametrised successor to the 16-to-8 byte FIFO in the sweeper/PLL datapath. Buffers IN_W-bit words and emits them as RATIO narrower slices of OUT_W = IN_W/RATIO bits. Both sides use valid/ready handshakes. Adds a selectable slice order, synchronous flush, a last-slice marker and fill-level outputs. It sits between wide sample producers (sweep generator, phase-detector accumulators) and narrow serial or byte links.

---
 rtl/fifo_conv_pkg.sv | 23 ++
 rtl/fifo_sdp_mem.sv | 19 +
 rtl/fifo_width_down_conv.sv | 73 +++++++
 tb/tb_fifo_width_down_conv.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_conv_pkg.sv
// fifo_conv_pkg: width and slice helpers shared by the width-down FIFO and its storage
package fifo_conv_pkg;
    localparam int MAX_W = 1024;
    function automatic int clog2_safe(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction
    function automatic int out_w(input int in_w, input int ratio);
        return in_w / ratio;
    endfunction
    function automatic int ptr_w(input int depth);
        return clog2_safe(depth);
    endfunction
    function automatic int cnt_w(input int depth);
        return clog2_safe(depth + 1);
    endfunction
    function automatic int lvl_w(input int depth, input int ratio);
        return clog2_safe(depth * ratio + 1);
    endfunction
    function automatic logic [MAX_W-1:0] slice_sel(input logic [MAX_W-1:0] word, input int idx,
                                                   input bit lsb_first, input int ratio, input int ow);
        return word >> ((lsb_first ? idx : ratio - 1 - idx) * ow);
    endfunction
endpackage

// File: rtl/fifo_sdp_mem.sv
// fifo_sdp_mem: simple dual-port array, synchronous write and asynchronous read, no reset
module fifo_sdp_mem #(
    parameter int W = 16,
    parameter int DEPTH = 16,
    parameter int AW = 4
)(
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);
    logic [W-1:0] mem [DEPTH];
    // write port
    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;
    assign rdata = mem[raddr];
endmodule

// File: rtl/fifo_width_down_conv.sv
// fifo_width_down_conv: first-word-fall-through FIFO storing wide words and emitting narrow slices
module fifo_width_down_conv
    import fifo_conv_pkg::*;
#(
    parameter int IN_W = 16,
    parameter int RATIO = 2,
    parameter int DEPTH = 16,
    parameter bit LSB_FIRST = 1
)(
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               flush,
    input  logic                               s_valid,
    input  logic [IN_W-1:0]                    s_data,
    output logic                               s_ready,
    output logic                               m_valid,
    output logic [IN_W/RATIO-1:0]              m_data,
    output logic                               m_last,
    input  logic                               m_ready,
    output logic                               full,
    output logic                               empty,
    output logic [$clog2(DEPTH+1)-1:0]         level_words,
    output logic [$clog2(DEPTH*RATIO+1)-1:0]   level_slices
);
    localparam int OUT_W = out_w(IN_W, RATIO);
    localparam int PTR_W = ptr_w(DEPTH);
    localparam int CNT_W = cnt_w(DEPTH);
    localparam int LVL_W = lvl_w(DEPTH, RATIO);
    localparam int IDX_W = clog2_safe(RATIO);
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic [IDX_W-1:0] slice_idx;
    logic [IN_W-1:0] rd_word;
    logic push, pop, last_slice, retire;
    assign full = count == CNT_W'(DEPTH);
    assign empty = count == '0;
    assign s_ready = !full;
    assign m_valid = !empty;
    assign push = s_valid && s_ready;
    assign pop = m_valid && m_ready;
    assign last_slice = slice_idx == IDX_W'(RATIO - 1);
    assign retire = pop && last_slice;
    assign m_last = m_valid && last_slice;
    assign m_data = m_valid ? OUT_W'(slice_sel(MAX_W'(rd_word), int'(slice_idx), LSB_FIRST, RATIO, OUT_W)) : '0;
    assign level_words = count;
    assign level_slices = LVL_W'(count) * LVL_W'(RATIO) - LVL_W'(slice_idx);
    fifo_sdp_mem #(.W(IN_W), .DEPTH(DEPTH), .AW(PTR_W)) u_mem (
        .clk   (clk),
        .we    (push && !flush),
        .waddr (wr_ptr),
        .wdata (s_data),
        .raddr (rd_ptr),
        .rdata (rd_word)
    );
    // pointers, occupancy and slice position; flush clears exactly like reset and wins over push/pop
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
            slice_idx <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
            slice_idx <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) slice_idx <= last_slice ? '0 : slice_idx + 1'b1;
            if (retire) rd_ptr <= rd_ptr + 1'b1;
            if (push != retire) count <= push ? count + 1'b1 : count - 1'b1;
        end
endmodule

// File: tb/tb_fifo_width_down_conv.sv
// tb_fifo_width_down_conv: directed checks of the width-down FIFO in two configurations
module tb_fifo_width_down_conv;
    logic clk = 0, rst = 1, flush = 0;
    logic s_valid = 0, m_ready = 0;
    logic [15:0] s_data = '0;
    logic s_ready, m_valid, m_last, full, empty;
    logic [7:0] m_data;
    logic [4:0] level_words;
    logic [5:0] level_slices;
    logic q_flush = 0, q_s_valid = 0, q_m_ready = 0;
    logic [31:0] q_s_data = '0;
    logic q_s_ready, q_m_valid, q_m_last, q_full, q_empty;
    logic [7:0] q_m_data;
    logic [2:0] q_level_words;
    logic [4:0] q_level_slices;
    int checks = 0, failures = 0;
    logic [15:0] sb[$];
    int ms = 0;
    logic [15:0] ew;

    fifo_width_down_conv dut (
        .clk(clk), .rst(rst), .flush(flush), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready), .full(full),
        .empty(empty), .level_words(level_words), .level_slices(level_slices)
    );
    fifo_width_down_conv #(.IN_W(32), .RATIO(4), .DEPTH(4), .LSB_FIRST(0)) dut4 (
        .clk(clk), .rst(rst), .flush(q_flush), .s_valid(q_s_valid), .s_data(q_s_data), .s_ready(q_s_ready),
        .m_valid(q_m_valid), .m_data(q_m_data), .m_last(q_m_last), .m_ready(q_m_ready), .full(q_full),
        .empty(q_empty), .level_words(q_level_words), .level_slices(q_level_slices)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_s_ready"}, s_ready, 1);
        check({tag, "_m_valid"}, m_valid, 0);
        check({tag, "_m_data"}, m_data, 0);
        check({tag, "_m_last"}, m_last, 0);
        check({tag, "_full"}, full, 0);
        check({tag, "_empty"}, empty, 1);
        check({tag, "_lw"}, level_words, 0);
        check({tag, "_ls"}, level_slices, 0);
    endtask

    initial begin
        tick();
        check_idle("rst");
        check("rst_q_m_valid", q_m_valid, 0);
        tick();
        #2 rst = 0;
        tick();
        check_idle("post_rst");

        s_valid = 1; s_data = 16'hA1B2;
        tick();
        s_valid = 0;
        check("d_valid", m_valid, 1);
        check("d_data0", m_data, 8'hB2);
        check("d_last0", m_last, 0);
        check("d_ls0", level_slices, 2);
        m_ready = 1;
        tick();
        check("d_data1", m_data, 8'hA1);
        check("d_last1", m_last, 1);
        check("d_ls1", level_slices, 1);
        check("d_lw1", level_words, 1);
        tick();
        m_ready = 0;
        check("d_empty", empty, 1);
        check("d_data_empty", m_data, 0);

        q_s_valid = 1; q_s_data = 32'h11223344;
        tick();
        q_s_valid = 0; q_m_ready = 1;
        check("q_d0", q_m_data, 8'h11); check("q_l0", q_m_last, 0); check("q_ls0", q_level_slices, 4);
        tick();
        check("q_d1", q_m_data, 8'h22); check("q_l1", q_m_last, 0); check("q_ls1", q_level_slices, 3);
        tick();
        check("q_d2", q_m_data, 8'h33); check("q_l2", q_m_last, 0); check("q_ls2", q_level_slices, 2);
        tick();
        check("q_d3", q_m_data, 8'h44); check("q_l3", q_m_last, 1); check("q_ls3", q_level_slices, 1);
        tick();
        q_m_ready = 0;
        check("q_ls4", q_level_slices, 0); check("q_valid4", q_m_valid, 0); check("q_data4", q_m_data, 0);

        for (int i = 0; i < 16; i++) begin
            s_valid = 1; s_data = 16'(i * 256 + 128 + i);
            tick();
        end
        check("f_full", full, 1);
        check("f_s_ready", s_ready, 0);
        check("f_lw", level_words, 16);
        check("f_ls", level_slices, 32);
        s_data = 16'hDEAD;
        tick();
        check("f_ignored_lw", level_words, 16);
        check("f_w0_lo", m_data, 8'h80);
        m_ready = 1;
        tick();
        check("f_w0_hi", m_data, 8'h00);
        check("f_w0_last", m_last, 1);
        check("f_still_full", full, 1);
        tick();
        check("f_retired_lw", level_words, 15);
        check("f_retired_s_ready", s_ready, 1);
        check("f_w1_lo", m_data, 8'h81);
        m_ready = 0;
        tick();
        s_valid = 0;
        check("f_refill_lw", level_words, 16);
        check("f_refill_full", full, 1);
        m_ready = 1;
        for (int w = 1; w <= 16; w++) begin
            ew = (w < 16) ? 16'(w * 256 + 128 + w) : 16'hDEAD;
            check($sformatf("f_rd%0d_lo", w), m_data, ew[7:0]);
            check($sformatf("f_rd%0d_lastlo", w), m_last, 0);
            tick();
            check($sformatf("f_rd%0d_hi", w), m_data, ew[15:8]);
            check($sformatf("f_rd%0d_lasthi", w), m_last, 1);
            tick();
        end
        m_ready = 0;
        check("f_drained", empty, 1);

        for (int i = 0; i < 8; i++) begin
            s_valid = 1; s_data = 16'(16'h3300 + i * 16'h0111);
            sb.push_back(s_data);
            tick();
        end
        ms = 0;
        for (int k = 0; k < 200; k++) begin
            s_valid = (k % 2 == 0); s_data = 16'(16'h5A00 + k * 7); m_ready = 1;
            if (m_valid) check($sformatf("c_data%0d", k), m_data, ms == 0 ? sb[0][7:0] : sb[0][15:8]);
            else check($sformatf("c_valid%0d", k), m_valid, 1);
            if (s_valid && s_ready) sb.push_back(s_data);
            if (m_valid) begin
                if (ms == 1) begin void'(sb.pop_front()); ms = 0; end
                else ms = 1;
            end
            tick();
            check($sformatf("c_lw%0d", k), level_words, (k % 2 == 0) ? 9 : 8);
        end
        s_valid = 0;
        for (int k = 0; k < 40; k++) begin
            if (!m_valid) break;
            check($sformatf("c_drain%0d", k), m_data, ms == 0 ? sb[0][7:0] : sb[0][15:8]);
            if (ms == 1) begin void'(sb.pop_front()); ms = 0; end
            else ms = 1;
            tick();
        end
        m_ready = 0;
        check("c_empty", empty, 1);
        check("c_sb_empty", sb.size(), 0);

        s_valid = 1; s_data = 16'h1234;
        tick();
        s_data = 16'h5678;
        tick();
        s_valid = 0;
        check("x_lo", m_data, 8'h34);
        m_ready = 1;
        tick();
        check("x_hi", m_data, 8'h12);
        flush = 1; s_valid = 1; s_data = 16'hBEEF;
        tick();
        flush = 0; s_valid = 0; m_ready = 0;
        check_idle("flush");
        tick();
        check("flush_absent", m_valid, 0);
        s_valid = 1; s_data = 16'hCAFE;
        tick();
        s_valid = 0;
        check("flush_next_lo", m_data, 8'hFE);
        check("flush_next_ls", level_slices, 2);
        check("flush_next_last", m_last, 0);

        m_ready = 1;
        tick();
        m_ready = 0;
        check("ar_pre_data", m_data, 8'hCA);
        check("ar_pre_last", m_last, 1);
        #2 rst = 1;
        #1;
        check_idle("async_rst");
        tick();
        #3 rst = 0;
        tick();
        check("ar_no_spurious", m_valid, 0);
        s_valid = 1; s_data = 16'h7788;
        tick();
        s_valid = 0; m_ready = 1;
        check("ar_lo", m_data, 8'h88);
        check("ar_lo_last", m_last, 0);
        tick();
        check("ar_hi", m_data, 8'h77);
        check("ar_hi_last", m_last, 1);
        tick();
        m_ready = 0;
        check("ar_empty", empty, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
